fifo_rptr_ctrl: RTL

//   Read-domain pointer and flag controller for the async FIFO.
//   - Adds a built-in multi-stage Gray synchroniser for the write pointer.
//   - Uses an extra wrap bit on the pointer, so depth and width are fully parametrised.
//   - Provides registered empty, a programmable almost-empty flag, a fill level and an underflow pulse.
//   - Drives the RAM read address and returns its Gray read pointer to the write domain.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/gray_ptr_sync.sv | 29 ++
 rtl/fifo_rptr_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers (read and write side).
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_MAX_W   = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  // Callers zero-extend their pointer into ptr_wide_t and size-cast the result back.
  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_ptr_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rptr_ctrl.sv
// Read-domain pointer and flag controller for the async FIFO.
module fifo_rptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rd_clk,
  input  logic              rd_reset,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gr,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gr,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0] wr_gr_s;
  logic [PW-1:0] wr_bin_s;
  logic          accept;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_ptr_gr_q, rd_ptr_gr_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic          uf_q, uf_d;

  gray_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i (rd_clk),
    .rst_i (rd_reset),
    .d_i   (wr_ptr_gr),
    .q_o   (wr_gr_s)
  );

  // Flags are derived from the next pointer so the edge that reads the last
  // entry also raises empty; the wrap bit keeps full (level=DEPTH) distinct from empty.
  always_comb begin
    wr_bin_s    = PW'(gray2bin(ptr_wide_t'(wr_gr_s)));
    accept      = rd_en & ~empty_q;
    rd_ptr_d    = rd_ptr_q + PW'(accept);
    rd_ptr_gr_d = PW'(bin2gray(ptr_wide_t'(rd_ptr_d)));
    level_d     = wr_bin_s - rd_ptr_d;
    empty_d     = (wr_bin_s == rd_ptr_d);
    ae_d        = (level_d <= ae_thresh);
    uf_d        = rd_en & empty_q;
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      rd_ptr_q    <= '0;
      rd_ptr_gr_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      uf_q        <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_ptr_gr_q <= rd_ptr_gr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      uf_q        <= uf_d;
    end
  end

  assign rd_addr         = rd_ptr_q[ADDR_W-1:0];
  assign rd_ptr_gr       = rd_ptr_gr_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = ae_q;
  assign rd_level        = level_q;
  assign rd_underflow    = uf_q;

  // The write side must never run more than DEPTH entries ahead of the reader.
  a_level_legal: assert property (@(posedge rd_clk) disable iff (rd_reset)
    (wr_bin_s - rd_ptr_q) <= DEPTH_P);

endmodule
